// File: rtl/rv_stream_checker.sv
// rv_stream_checker: receiving end of an 8-bit incrementing ready/valid stream.
// Throttles ready with an LFSR, locks onto the first accepted value and flags
// every accepted beat that is not previous+1 (mod 2^WIDTH).
// Optional protocol monitor: define RV_PROTO_CHECK_EN to build it.
//
// state  | meaning
// IDLE   | disabled, ready low, LFSR frozen
// SYNC   | waiting for the first accepted beat to learn the sequence
// LOCKED | checking every accepted beat against expected
// PAUSED | enable dropped while locked; expected retained
module rv_stream_checker #(
    parameter int         WIDTH     = 8,
    parameter int         CNT_W     = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_throttle_en,
    input  logic [7:0]       i_throttle_thresh,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_beat_count,
    output logic [WIDTH-1:0] o_expected,
    output logic             o_proto_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_lfsr;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_beat_count;
    logic [WIDTH-1:0] r_expected;

    logic w_active;
    logic w_stall;
    logic w_accept;
    logic w_clear;
    logic w_mismatch;
    logic w_lfsr_fb;

    assign w_active   = (r_state == S_SYNC) || (r_state == S_LOCKED);
    assign w_stall    = i_throttle_en && (r_lfsr < i_throttle_thresh);
    assign o_ready    = i_enable && !i_clear && w_active && !w_stall;
    assign w_accept   = i_valid && o_ready;
    assign w_clear    = i_clear && (r_state != S_IDLE);
    assign w_mismatch = w_accept && (r_state == S_LOCKED) && (i_data != r_expected);
    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    assign o_locked     = (r_state == S_LOCKED);
    assign o_err_pulse  = r_err_pulse;
    assign o_err_count  = r_err_count;
    assign o_beat_count = r_beat_count;
    assign o_expected   = r_expected;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; clear overrides everything outside IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (w_clear) begin
            w_state_nxt = S_SYNC;
        end else begin
            case (r_state)
                S_IDLE:   if (i_enable) w_state_nxt = S_SYNC;
                S_SYNC: begin
                    if (!i_enable)     w_state_nxt = S_IDLE;
                    else if (w_accept) w_state_nxt = S_LOCKED;
                end
                S_LOCKED: if (!i_enable) w_state_nxt = S_PAUSED;
                S_PAUSED: if (i_enable)  w_state_nxt = S_LOCKED;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Throttle LFSR, x^8+x^6+x^5+x^4+1, free-running outside IDLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state != S_IDLE) begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // Sequence tracking, error pulse and counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_pulse  <= 1'b0;
            r_err_count  <= '0;
            r_beat_count <= '0;
            r_expected   <= '0;
        end else if (w_clear) begin
            r_err_pulse  <= 1'b0;
            r_err_count  <= '0;
            r_beat_count <= '0;
        end else begin
            r_err_pulse <= w_mismatch;
            if (w_accept) begin
                r_beat_count <= r_beat_count + CNT_W'(1);
                // Always re-track so a skip costs exactly one error
                r_expected   <= i_data + WIDTH'(1);
            end
            if (w_mismatch && (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

`ifdef RV_PROTO_CHECK_EN
    logic             r_prev_valid;
    logic             r_prev_ready;
    logic [WIDTH-1:0] r_prev_data;
    logic             r_proto_err;

    // Flag a stalled beat that was withdrawn or changed before acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_valid <= 1'b0;
            r_prev_ready <= 1'b0;
            r_prev_data  <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_prev_valid <= i_valid;
            r_prev_ready <= o_ready;
            r_prev_data  <= i_data;
            r_proto_err  <= !w_clear && w_active && r_prev_valid && !r_prev_ready &&
                            (!i_valid || (i_data != r_prev_data));
        end
    end

    assign o_proto_err = r_proto_err;
`else
    assign o_proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_stream_checker.sv
// Directed self-checking bench for rv_stream_checker.
module tb_rv_stream_checker;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic        throttle_en;
    logic [7:0]  throttle_thresh;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] beat_count;
    logic [7:0]  expected;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

`ifdef RV_PROTO_CHECK_EN
    localparam logic PROTO = 1'b1;
`else
    localparam logic PROTO = 1'b0;
`endif

    rv_stream_checker #(.WIDTH(8), .CNT_W(16), .LFSR_SEED(8'hA5)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_enable         (enable),
        .i_clear          (clear),
        .i_throttle_en    (throttle_en),
        .i_throttle_thresh(throttle_thresh),
        .i_valid          (valid),
        .i_data           (data),
        .o_ready          (ready),
        .o_locked         (locked),
        .o_err_pulse      (err_pulse),
        .o_err_count      (err_count),
        .o_beat_count     (beat_count),
        .o_expected       (expected),
        .o_proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted (bounded)
    task automatic send(input logic [7:0] d);
        int n;
        valid = 1'b1;
        data  = d;
        n = 0;
        #1;
        while (!ready && n < 64) begin
            tick();
            #1;
            n++;
        end
        if (n == 64) chk("send_timeout", 32'd1, 32'd0);
        tick();
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    logic [7:0] m;
    logic [7:0] d;
    logic       acc;
    int         nacc;

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; throttle_en = 1'b0;
        throttle_thresh = 8'h00; valid = 1'b0; data = 8'h00;
        #2;
        chk("rst_ready", ready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_beat", beat_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_expected", expected, 0);
        chk("rst_proto", proto_err, 0);

        // Basic lock and count: 00..09 back-to-back
        tick();
        rst_n  = 1'b1;
        enable = 1'b1;
        #1;
        chk("first_enable_ready", ready, 0);
        tick();
        chk("sync_ready", ready, 1);
        send(8'h00);
        chk("locked_after_00", locked, 1);
        for (int i = 1; i < 10; i++) send(i[7:0]);
        valid = 1'b0;
        chk("t1_beat", beat_count, 10);
        chk("t1_err", err_count, 0);
        chk("t1_expected", expected, 8'h0A);

        // Wrap through FF -> 00
        clear = 1'b1;
        #1;
        chk("clear_ready", ready, 0);
        tick();
        clear = 1'b0;
        chk("clear_unlocked", locked, 0);
        chk("clear_beat", beat_count, 0);
        send(8'hFC);
        send(8'hFD); chk("wrap_fd", err_pulse, 0);
        send(8'hFE); chk("wrap_fe", err_pulse, 0);
        send(8'hFF); chk("wrap_ff", err_pulse, 0);
        send(8'h00); chk("wrap_00", err_pulse, 0);
        send(8'h01); chk("wrap_01", err_pulse, 0);
        valid = 1'b0;
        chk("wrap_expected", expected, 8'h02);
        chk("wrap_err", err_count, 0);
        chk("wrap_beat", beat_count, 6);

        // Skip 10,11,13,14: one error only
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(8'h10); chk("skip_10", err_pulse, 0);
        send(8'h11); chk("skip_11", err_pulse, 0);
        send(8'h13); chk("skip_13", err_pulse, 1);
        send(8'h14); chk("skip_14", err_pulse, 0);
        valid = 1'b0;
        chk("skip_err", err_count, 1);
        chk("skip_expected", expected, 8'h15);

        // Async reset mid-stream, no clock edge
        valid = 1'b1;
        data  = 8'h15;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", ready, 0);
        chk("arst_locked", locked, 0);
        chk("arst_err", err_count, 0);
        chk("arst_beat", beat_count, 0);
        chk("arst_expected", expected, 0);
        chk("arst_errp", err_pulse, 0);

        // Throttled stream against a reference LFSR from seed A5
        valid = 1'b0;
        throttle_en = 1'b1;
        throttle_thresh = 8'h80;
        rst_n = 1'b1;
        tick();
        m = 8'hA5;
        d = 8'h30;
        nacc = 0;
        for (int c = 0; c < 40; c++) begin
            valid = 1'b1;
            data  = d;
            #1;
            chk("thr_ready", ready, (m >= 8'h80) ? 1 : 0);
            acc = ready;
            tick();
            m = lfsr_step(m);
            if (acc) begin
                d = d + 8'd1;
                nacc++;
            end
        end
        valid = 1'b0;
        chk("thr_err", err_count, 0);
        chk("thr_beat", beat_count, nacc);
        chk("thr_expected", expected, d);
        chk("thr_locked", locked, 1);

        // Pause / resume, then clear and re-sync
        throttle_en = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(8'h3F);
        valid = 1'b0;
        chk("pause_pre_expected", expected, 8'h40);
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("pause_ready", ready, 0);
            tick();
        end
        chk("paused_locked", locked, 0);
        enable = 1'b1;
        tick();
        send(8'h40);
        valid = 1'b0;
        chk("resume_errp", err_pulse, 0);
        chk("resume_err", err_count, 0);
        chk("resume_expected", expected, 8'h41);
        chk("resume_beat", beat_count, 2);
        clear = 1'b1;
        valid = 1'b1;
        data  = 8'h55;
        #1;
        chk("clear2_ready", ready, 0);
        tick();
        clear = 1'b0;
        valid = 1'b0;
        chk("clear2_beat", beat_count, 0);
        chk("clear2_err", err_count, 0);
        chk("clear2_locked", locked, 0);
        send(8'h7F);
        valid = 1'b0;
        chk("resync_errp", err_pulse, 0);
        chk("resync_locked", locked, 1);
        chk("resync_expected", expected, 8'h80);
        chk("resync_beat", beat_count, 1);

        // Protocol monitor: stalled beat changes data 20 -> 21
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        throttle_en = 1'b1;
        throttle_thresh = 8'hFF;
        tick();
        valid = 1'b1;
        data  = 8'h20;
        #1;
        chk("proto_stall_ready", ready, 0);
        tick();
        chk("proto_quiet", proto_err, 0);
        data = 8'h21;
        tick();
        chk("proto_pulse", proto_err, PROTO);
        tick();
        chk("proto_single", proto_err, 0);
        valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
